// File: rtl/calc_controller.sv
// rtl/calc_controller.sv - command sequencer turning button edges into one-cycle ALU instructions
// Optional CALC_CHAIN_EN: a successful COMPUTE writes result[3:0] back into operand A.
module calc_controller #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic [1:0] op_sel,
  input  logic       btn_compute,
  input  logic       btn_load_a,
  input  logic       btn_load_b,
  input  logic       btn_show,
  input  logic [7:0] alu_result,
  input  logic       alu_done,
  input  logic       alu_div_by_zero,
  input  logic       alu_negative,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] op_code,
  output logic [1:0] compute_op,
  output logic       busy,
  output logic [7:0] disp_value,
  output logic       neg_flag,
  output logic       err_div0,
  output logic       err_timeout
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_NOOP     = 3'b000;
  localparam logic [2:0] OP_DISP_A   = 3'b010;
  localparam logic [2:0] OP_DISP_B   = 3'b100;
  localparam logic [2:0] OP_COMPUTE  = 3'b101;
  localparam logic [2:0] OP_DISP_RES = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    btn_q, btn_d, btn_edge;
  logic [3:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]    compute_op_q, compute_op_d;
  logic [2:0]    op_code_q, op_code_d;
  logic [7:0]    disp_q, disp_d;
  logic          neg_q, neg_d, div0_q, div0_d, tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef CALC_CHAIN_EN
  logic          chain_q, chain_d;
`endif

  // Bit order doubles as priority: lowest index wins.
  assign btn_d    = {btn_show, btn_load_b, btn_load_a, btn_compute};
  assign btn_edge = btn_d & ~btn_q;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    compute_op_d = compute_op_q;
    op_code_d    = OP_NOOP;
    disp_d       = disp_q;
    neg_d        = neg_q;
    div0_d       = div0_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
`ifdef CALC_CHAIN_EN
    chain_d      = chain_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|btn_edge) begin
          neg_d   = 1'b0;
          div0_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_ISSUE;
`ifdef CALC_CHAIN_EN
          chain_d = btn_edge[0];
`endif
          if (btn_edge[0]) begin
            compute_op_d = op_sel;
            op_code_d    = OP_COMPUTE;
          end else if (btn_edge[1]) begin
            alu_a_d   = sw;
            op_code_d = OP_DISP_A;
          end else if (btn_edge[2]) begin
            alu_b_d   = sw;
            op_code_d = OP_DISP_B;
          end else begin
            op_code_d = OP_DISP_RES;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response on the expiry cycle still counts as a response.
        if (alu_div_by_zero) begin
          disp_d  = 8'h00;
          div0_d  = 1'b1;
          state_d = S_IDLE;
        end else if (alu_done) begin
          disp_d  = alu_result;
          neg_d   = alu_negative;
          state_d = S_IDLE;
`ifdef CALC_CHAIN_EN
          if (chain_q) alu_a_d = alu_result[3:0];
`endif
        end else if (cnt_q == CNT_LAST) begin
          disp_d  = 8'hFF;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      btn_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      compute_op_q <= '0;
      op_code_q    <= OP_NOOP;
      disp_q       <= '0;
      neg_q        <= 1'b0;
      div0_q       <= 1'b0;
      tmo_q        <= 1'b0;
      cnt_q        <= '0;
`ifdef CALC_CHAIN_EN
      chain_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      btn_q        <= btn_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      compute_op_q <= compute_op_d;
      op_code_q    <= op_code_d;
      disp_q       <= disp_d;
      neg_q        <= neg_d;
      div0_q       <= div0_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
`ifdef CALC_CHAIN_EN
      chain_q      <= chain_d;
`endif
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign op_code     = op_code_q;
  assign compute_op  = compute_op_q;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign disp_value  = disp_q;
  assign neg_flag    = neg_q;
  assign err_div0    = div0_q;
  assign err_timeout = tmo_q;
endmodule

// File: tb/tb_calc_controller.sv
// tb/tb_calc_controller.sv - directed bench for calc_controller with a delay-programmable stub ALU
// Honours CALC_CHAIN_EN for the operand-A writeback expectations.
module tb_calc_controller;
  localparam logic [3:0] B_COMP = 4'b0001;
  localparam logic [3:0] B_LA   = 4'b0010;
  localparam logic [3:0] B_LB   = 4'b0100;
  localparam logic [3:0] B_SHOW = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic [1:0] op_sel;
  logic       btn_compute, btn_load_a, btn_load_b, btn_show;
  logic [7:0] alu_result;
  logic       alu_done, alu_div_by_zero, alu_negative;
  logic [3:0] alu_a, alu_b;
  logic [2:0] op_code;
  logic [1:0] compute_op;
  logic       busy;
  logic [7:0] disp_value;
  logic       neg_flag, err_div0, err_timeout;

  int errors = 0;
  int checks = 0;

  calc_controller #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .sw(sw), .op_sel(op_sel),
    .btn_compute(btn_compute), .btn_load_a(btn_load_a),
    .btn_load_b(btn_load_b), .btn_show(btn_show),
    .alu_result(alu_result), .alu_done(alu_done),
    .alu_div_by_zero(alu_div_by_zero), .alu_negative(alu_negative),
    .alu_a(alu_a), .alu_b(alu_b), .op_code(op_code), .compute_op(compute_op),
    .busy(busy), .disp_value(disp_value), .neg_flag(neg_flag),
    .err_div0(err_div0), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Stub ALU: answers alu_delay cycles after the nominal response cycle, or never when muted.
  int         alu_delay = 0;
  logic       alu_mute  = 1'b0;
  int         stub_cnt;
  logic [2:0] stub_op;
  logic [7:0] last_res;
  logic [7:0] stub_res;
  logic       stub_neg, fire;

  always @(posedge clk) begin
    if (!reset) begin
      stub_cnt <= 0;
      stub_op  <= 3'b000;
      last_res <= 8'h00;
    end else begin
      if (fire && stub_op == 3'b101) last_res <= stub_res;
      if (op_code != 3'b000 && !alu_mute) begin
        stub_op  <= op_code;
        stub_cnt <= alu_delay + 1;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  always_comb begin
    stub_res = 8'h00;
    stub_neg = 1'b0;
    case (stub_op)
      3'b010: stub_res = {4'h0, alu_a};
      3'b100: stub_res = {4'h0, alu_b};
      3'b110: stub_res = last_res;
      3'b101: begin
        case (compute_op)
          2'b00: stub_res = {4'h0, alu_a} + {4'h0, alu_b};
          2'b01: begin
            stub_res = {4'h0, alu_a} - {4'h0, alu_b};
            stub_neg = alu_a < alu_b;
          end
          2'b10: stub_res = {4'h0, alu_a} * {4'h0, alu_b};
          default: stub_res = (alu_b == 4'h0) ? 8'hFF : {4'h0, alu_a / alu_b};
        endcase
      end
      default: stub_res = 8'h00;
    endcase
  end

  assign fire            = (stub_cnt == 1);
  assign alu_done        = fire;
  assign alu_div_by_zero = fire && stub_op == 3'b101 && compute_op == 2'b11 && alu_b == 4'h0;
  assign alu_negative    = fire && stub_neg;
  assign alu_result      = fire ? stub_res : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_show, btn_load_b, btn_load_a, btn_compute} = b;
  endtask

  // Edge in cycle 0, checks ISSUE (cycle 1) and WAIT entry (cycle 2); returns in cycle 2.
  task automatic cmd(input string tag, input logic [3:0] b, input logic [2:0] exp_op);
    set_btns(b);
    step();
    check({tag, "_op"}, op_code, exp_op);
    check({tag, "_busy1"}, busy, 1);
    set_btns(4'b0000);
    step();
    check({tag, "_op0"}, op_code, 3'b000);
    check({tag, "_busy2"}, busy, 1);
  endtask

  task automatic load(input string tag, input logic [3:0] b, input logic [3:0] v);
    sw = v;
    cmd(tag, b, (b == B_LA) ? 3'b010 : 3'b100);
    step();
    check({tag, "_idle"}, busy, 0);
    check({tag, "_disp"}, disp_value, {4'h0, v});
  endtask

  initial begin
    reset = 1'b0;
    sw = 4'h0;
    op_sel = 2'b00;
    set_btns(4'b0000);
    step();
    step();
    check("rst_op", op_code, 0);
    check("rst_busy", busy, 0);
    check("rst_disp", disp_value, 0);
    check("rst_a", alu_a, 0);
    check("rst_flags", {neg_flag, err_div0, err_timeout}, 0);
    reset = 1'b1;
    step();

    load("ld_a7", B_LA, 4'd7);
    check("ld_a7_reg", alu_a, 4'd7);
    load("ld_b3", B_LB, 4'd3);
    check("ld_b3_reg", alu_b, 4'd3);

    op_sel = 2'b00;
    set_btns(B_COMP);
    step();
    check("add_op", op_code, 3'b101);
    check("add_cop", compute_op, 2'b00);
    set_btns(4'b0000);
    step();
    check("add_op0", op_code, 3'b000);
    step();
    check("add_disp", disp_value, 8'h0A);
    check("add_neg", neg_flag, 0);
`ifdef CALC_CHAIN_EN
    check("add_chain", alu_a, 4'hA);
`else
    check("add_chain", alu_a, 4'h7);
`endif

    load("ld_a3", B_LA, 4'd3);
    load("ld_b7", B_LB, 4'd7);
    op_sel = 2'b01;
    cmd("sub", B_COMP, 3'b101);
    step();
    check("sub_disp", disp_value, 8'hFC);
    check("sub_neg", neg_flag, 1);
`ifdef CALC_CHAIN_EN
    check("sub_chain", alu_a, 4'hC);
`else
    check("sub_chain", alu_a, 4'h3);
`endif
    set_btns(B_SHOW);
    step();
    check("show_op", op_code, 3'b110);
    check("show_negclr", neg_flag, 0);
    set_btns(4'b0000);
    step();
    step();
    check("show_disp", disp_value, 8'hFC);
    check("show_neg", neg_flag, 0);

    load("ld_a9", B_LA, 4'd9);
    load("ld_b0", B_LB, 4'd0);
    op_sel = 2'b11;
    cmd("div0", B_COMP, 3'b101);
    step();
    check("div0_flag", err_div0, 1);
    check("div0_disp", disp_value, 8'h00);
    check("div0_a", alu_a, 4'd9);
    check("div0_neg", neg_flag, 0);
    step();
    step();
    check("div0_sticky", err_div0, 1);
    sw = 4'd2;
    set_btns(B_LB);
    step();
    check("div0_clr", err_div0, 0);
    set_btns(4'b0000);
    step();
    step();
    check("ld_b2_disp", disp_value, 8'h02);

    alu_mute = 1'b1;
    op_sel = 2'b00;
    cmd("tmo", B_COMP, 3'b101);
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin
        sw = 4'hF;
        set_btns(B_LB);
      end else begin
        set_btns(4'b0000);
      end
      step();
    end
    check("tmo_busy_last", busy, 1);
    check("tmo_notyet", err_timeout, 0);
    step();
    check("tmo_idle", busy, 0);
    check("tmo_flag", err_timeout, 1);
    check("tmo_disp", disp_value, 8'hFF);
    check("tmo_a", alu_a, 4'd9);
    check("tmo_b_kept", alu_b, 4'd2);
    step();
    check("tmo_dropped", busy, 0);

    alu_mute = 1'b0;
    alu_delay = 14;
    cmd("late", B_COMP, 3'b101);
    for (int i = 0; i < 14; i++) step();
    check("late_busy", busy, 1);
    step();
    check("late_idle", busy, 0);
    check("late_tmo", err_timeout, 0);
    check("late_disp", disp_value, 8'h0B);
    alu_delay = 0;

    load("ld_a4", B_LA, 4'd4);
    sw = 4'd5;
    set_btns(B_COMP | B_LA);
    step();
    check("prio_op", op_code, 3'b101);
    check("prio_a", alu_a, 4'd4);
    set_btns(4'b0000);
    step();
    step();
    check("prio_disp", disp_value, 8'h06);
`ifdef CALC_CHAIN_EN
    check("prio_chain", alu_a, 4'd6);
`else
    check("prio_chain", alu_a, 4'd4);
`endif

    alu_mute = 1'b1;
    op_sel = 2'b10;
    cmd("rstw", B_COMP, 3'b101);
    step();
    check("rstw_busy_pre", busy, 1);
    reset = 1'b0;
    step();
    check("rstw_busy", busy, 0);
    check("rstw_op", op_code, 0);
    check("rstw_ab", {alu_a, alu_b}, 0);
    check("rstw_cop", compute_op, 0);
    check("rstw_disp", disp_value, 0);
    check("rstw_flags", {neg_flag, err_div0, err_timeout}, 0);
    reset = 1'b1;
    step();
    check("rstw_stay", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/calc_controller.md
# calc_controller

Command sequencer for the 4-bit binary calculator. It turns debounced board buttons and switches into single-cycle ALU instructions, waits for the ALU's `done` or `div_by_zero` response, and latches the result and status flags for the display path. It sits between the board I/O and the ALU, acting as the initiator of the op_code/done exchange.

## Interface
- `TIMEOUT_CYCLES`, 15 — cycles in WAIT without an ALU response before a timeout error is declared; valid range 2..255.
- `clk` input 1 — system clock.
- `reset` input 1 — synchronous, active-low reset (sampled on rising `clk`; low clears the block).
- `sw` input 4 — operand switches.
- `op_sel` input 2 — compute operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- `btn_compute`, `btn_load_a`, `btn_load_b`, `btn_show` input 1 each — debounced level buttons; only rising edges act.
- `alu_result` input 8 — ALU result.
- `alu_done`, `alu_div_by_zero`, `alu_negative` input 1 each — ALU status.
- `alu_a`, `alu_b` output 4 each — operand registers driven to the ALU.
- `op_code` output 3 — ALU instruction: 000 NOOP, 010 DISPLAY A, 100 DISPLAY B, 101 COMPUTE, 110 DISPLAY RESULT.
- `compute_op` output 2 — latched `op_sel`.
- `busy` output 1 — high in ISSUE and WAIT.
- `disp_value` output 8 — last captured value.
- `neg_flag`, `err_div0`, `err_timeout` output 1 each — sticky status; cleared when the next command is accepted.

## Operation
- Edge detection:
  - Each button has a 1-cycle delay register; `edge = btn & ~btn_q`.
  - The delay registers reset to 0.
  - Edges seen outside IDLE are discarded, not queued.
- Priority when several edges occur in the same IDLE cycle: compute > load_a > load_b > show. Lower-priority edges in that cycle are dropped.
- States: IDLE, ISSUE, WAIT.
- IDLE, on an accepted edge:
  - Clear `neg_flag`, `err_div0` and `err_timeout`.
  - load_a: `alu_a <= sw`; next `op_code = 010`.
  - load_b: `alu_b <= sw`; next `op_code = 100`.
  - compute: `compute_op <= op_sel`; next `op_code = 101`.
  - show: next `op_code = 110`.
  - Go to ISSUE.
- ISSUE:
  - `op_code` holds the instruction for exactly one cycle.
  - Next cycle: `op_code = 000`, timeout counter = 0, go to WAIT.
- WAIT:
  - `op_code` is 000; the counter increments each cycle.
  - `alu_done` = 1: `disp_value <= alu_result`, `neg_flag <= alu_negative`, go to IDLE.
  - `alu_div_by_zero` = 1: `disp_value <= 8'h00`, `err_div0 <= 1`, go to IDLE.
  - `done` and `div_by_zero` together: `div_by_zero` wins.
  - Counter reaches `TIMEOUT_CYCLES - 1` with no response: `err_timeout <= 1`, `disp_value <= 8'hFF`, go to IDLE.
- `alu_a` and `alu_b` change only on load commands (or on chain writeback, see Configuration).
- Reset (`reset` low at a rising edge), from any state including mid-WAIT:
  - State goes to IDLE.
  - `alu_a`, `alu_b`, `compute_op`, `op_code`, `disp_value` = 0.
  - `busy` and all flags = 0.
  - The timeout counter clears.

## Timing
- Cycle 0: IDLE samples an edge.
- Cycle 1: ISSUE; `op_code` is valid and `busy` = 1.
- Cycle 2: WAIT; the registered ALU response is visible; `op_code` = 000.
- End of cycle 2: capture. `disp_value` and the flags are valid in cycle 3, back in IDLE with `busy` = 0.
- Nominal command-to-display latency: 3 cycles.
- Back-to-back commands: minimum spacing is 3 cycles.
- Because `op_code` is driven for only one cycle, the ALU never re-executes a command.
- The counter is `$clog2(TIMEOUT_CYCLES)` bits wide.
- A response arriving on the same cycle the counter expires counts as a response, not a timeout.

## Configuration
- Macro: `CALC_CHAIN_EN`.
- Defined:
  - On `alu_done` for a COMPUTE command, `alu_a <= alu_result[3:0]` on the same edge as the capture.
  - Enables accumulator-style chaining of operations.
  - This writeback does not occur on div-by-zero, on timeout, or for DISPLAY commands.
- Undefined: `alu_a` changes only on load_a, and the writeback logic is absent.

## Test plan
- Reset then load:
  - Stimulus: hold `reset` low for 2 cycles; release; `sw = 4'd7`; pulse `btn_load_a`.
  - Response: `op_code = 010` for exactly one cycle; `busy` high for 2 cycles; `disp_value = 8'h07` 3 cycles after the edge.
- Add:
  - Stimulus: A = 7, B = 3, `op_sel = 00`; pulse `btn_compute`.
  - Response: `op_code = 101` and `compute_op = 00` for one cycle; `disp_value = 8'h0A`; `neg_flag = 0`.
  - With `CALC_CHAIN_EN` defined, `alu_a` becomes 4'hA.
- Subtract:
  - Stimulus: A = 3, B = 7, `op_sel = 01`.
  - Response: `disp_value` equals the ALU result; `neg_flag = 1`.
  - Follow with a show command: `op_code = 110` and `neg_flag` cleared.
- Divide by zero:
  - Stimulus: A = 9, B = 0, `op_sel = 11`.
  - Response: `err_div0 = 1`; `disp_value = 8'h00`; `alu_a` unchanged even with `CALC_CHAIN_EN` defined.
- Timeout, priority and reset (stub ALU that never responds):
  - Stimulus: issue a compute.
  - Response: `err_timeout = 1` and `disp_value = 8'hFF` after `TIMEOUT_CYCLES` cycles in WAIT.
  - Stimulus: simultaneous compute and load_a edges.
  - Response: only 101 is issued.
  - Stimulus: assert `reset` mid-WAIT.
  - Response: IDLE and all outputs 0 on the next edge.
